// File: rtl/bitwise_pkg.sv
// Shared types for the bitwise scheduler: opcode and FSM state encodings.
package bitwise_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_PASS = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_e;

   localparam int OP_W = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first high request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   grant_idx
);

   logic           w_found;
   logic [IDW-1:0] w_idx;

   // Walk offsets 0..N_REQ-1 from ptr; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = IDW'((int'(ptr) + i) % N_REQ);
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            grant_idx    = w_idx;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bitwise_sched.sv
// Multi-requester bitwise ALU: round-robin accept, one op in flight,
// result returned with the owning requester's index.
module bitwise_sched
   import bitwise_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_REQ = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [2*N_REQ-1:0]     req_op,
   input  logic [WIDTH*N_REQ-1:0] req_a,
   input  logic [WIDTH*N_REQ-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [IDW-1:0]         rsp_id,
   output logic                   busy
);

   state_e           r_state;
   state_e           w_nextState;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_gIdx;
   op_e              r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_rspData;
   logic [IDW-1:0]   r_rspId;

   logic [N_REQ-1:0] w_grant;
   logic [IDW-1:0]   w_grantIdx;
   logic [N_REQ-1:0] w_reqReady;
   logic             w_accept;
   logic [OP_W-1:0]  w_selOp;
   logic [WIDTH-1:0] w_selA;
   logic [WIDTH-1:0] w_selB;
   logic [WIDTH-1:0] w_result;
   logic [IDW-1:0]   w_ptrNext;

   rr_arbiter #(
      .N_REQ(N_REQ),
      .IDW  (IDW)
   ) u_arb (
      .req      (req_valid),
      .ptr      (r_ptr),
      .grant    (w_grant),
      .grant_idx(w_grantIdx)
   );

   // Next-state and grant exposure; requests are only visible in IDLE.
   always_comb begin
      w_nextState = r_state;
      w_reqReady  = '0;
      case (r_state)
         IDLE: begin
            w_reqReady = w_grant;
            if (|w_grant) w_nextState = EXEC;
         end
         EXEC: w_nextState = RESP;
         RESP: if (rsp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   assign req_ready = rst ? '0 : w_reqReady;
   assign w_accept  = (r_state == IDLE) && (|w_grant);
   assign w_ptrNext = (w_grantIdx == IDW'(N_REQ - 1)) ? '0 : w_grantIdx + 1'b1;

   // One-hot mux of the winner's operands.
   always_comb begin
      w_selOp = '0;
      w_selA  = '0;
      w_selB  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_grant[k]) begin
            w_selOp = w_selOp | req_op[k*OP_W +: OP_W];
            w_selA  = w_selA  | req_a[k*WIDTH +: WIDTH];
            w_selB  = w_selB  | req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_result = r_a;
      case (r_op)
         OP_AND:  w_result = r_a & r_b;
         OP_OR:   w_result = r_a | r_b;
         OP_XOR:  w_result = r_a ^ r_b;
         OP_PASS: w_result = r_a;
         default: w_result = r_a;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // Capture the winning request and advance the pointer past it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr  <= '0;
         r_gIdx <= '0;
         r_op   <= OP_AND;
         r_a    <= '0;
         r_b    <= '0;
      end else if (w_accept) begin
         r_ptr  <= w_ptrNext;
         r_gIdx <= w_grantIdx;
         r_op   <= op_e'(w_selOp);
         r_a    <= w_selA;
         r_b    <= w_selB;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rspData <= '0;
         r_rspId   <= '0;
      end else if (r_state == EXEC) begin
         r_rspData <= w_result;
         r_rspId   <= r_gIdx;
      end
   end

   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_rspData;
   assign rsp_id    = r_rspId;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bitwise_sched.sv
// Scenario bench for bitwise_sched against a round-robin/bitwise reference model.
module tb_bitwise_sched;

   localparam int WIDTH = 32;
   localparam int N_REQ = 4;
   localparam int IDW   = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [2*N_REQ-1:0]     req_op;
   logic [WIDTH*N_REQ-1:0] req_a;
   logic [WIDTH*N_REQ-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [WIDTH-1:0]       rsp_data;
   logic [IDW-1:0]         rsp_id;
   logic                   busy;

   int passCount  = 0;
   int checkCount = 0;
   int mPtr       = 0;

   bitwise_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .IDW(IDW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_a    (req_a),
      .req_b    (req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_id   (rsp_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int modelWinner(input logic [N_REQ-1:0] mask);
      for (int off = 0; off < N_REQ; off++)
         if (mask[(mPtr + off) % N_REQ]) return (mPtr + off) % N_REQ;
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] modelOp(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return a;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] expectFor(input int k);
      return modelOp(req_op[k*2 +: 2], req_a[k*WIDTH +: WIDTH], req_b[k*WIDTH +: WIDTH]);
   endfunction

   task automatic setReq(input int k, input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_op[k*2 +: 2]       = op;
      req_a[k*WIDTH +: WIDTH] = a;
      req_b[k*WIDTH +: WIDTH] = b;
   endtask

   // Called just after a falling edge; waits for a grant, then for the response.
   task automatic runTxn(output logic [N_REQ-1:0] readyVec, output int g, output int lat,
                         output logic [WIDTH-1:0] d, output logic [IDW-1:0] id, output bit timedOut);
      timedOut = 1'b0; g = -1; lat = 0; readyVec = '0; d = '0; id = '0;
      #1;
      for (int c = 0; c < 20 && req_ready == '0; c++) begin
         @(posedge clk); @(negedge clk); #1;
      end
      if (req_ready == '0) begin
         timedOut = 1'b1;
         return;
      end
      readyVec = req_ready;
      for (int k = 0; k < N_REQ; k++) if (readyVec[k]) g = k;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); lat++; @(negedge clk); #1;
         if (rsp_valid) break;
      end
      if (!rsp_valid) timedOut = 1'b1;
      d  = rsp_data;
      id = rsp_id;
   endtask

   task automatic stepToIdle();
      req_valid = '0;
      @(posedge clk); @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      req_valid = 4'hF;
      #1;
      checkCount++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); else passCount++;
      checkCount++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passCount++;
      checkCount++; if (rsp_data !== '0) $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); else passCount++;
      checkCount++; if (rsp_id !== '0) $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
      @(negedge clk);
      rst  = 1'b0;
      mPtr = 0;
      #1;
      checkCount++; if (req_ready !== 4'b0001) $display("[TB] FAIL first_grant_after_reset: got %b expected 0001", req_ready); else passCount++;
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [N_REQ-1:0] rv; int g, lat; logic [WIDTH-1:0] d; logic [IDW-1:0] id; bit to;
      setReq(0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
      req_valid = 4'b0001;
      runTxn(rv, g, lat, d, id, to);
      mPtr = (g + 1) % N_REQ;
      checkCount++; if (to) $display("[TB] FAIL single_timeout: got timeout expected response"); else passCount++;
      checkCount++; if (rv !== 4'b0001) $display("[TB] FAIL single_ready: got %b expected 0001", rv); else passCount++;
      checkCount++; if (lat != 2) $display("[TB] FAIL single_latency: got %0d expected 2", lat); else passCount++;
      checkCount++; if (d !== 32'hF000_F000) $display("[TB] FAIL single_data: got %h expected f000f000", d); else passCount++;
      checkCount++; if (id !== 2'd0) $display("[TB] FAIL single_id: got %0d expected 0", id); else passCount++;
      stepToIdle();
   endtask

   task automatic test_opcodes();
      logic [N_REQ-1:0] rv; int g, lat; logic [WIDTH-1:0] d; logic [IDW-1:0] id; bit to;
      logic [WIDTH-1:0] expd [4] = '{32'h0A0A_0505, 32'hAFAF_5F5F, 32'hA5A5_5A5A, 32'hAAAA_5555};
      for (int op = 0; op < 4; op++) begin
         setReq(2, 2'(op), 32'hAAAA_5555, 32'h0F0F_0F0F);
         req_valid = 4'b0100;
         runTxn(rv, g, lat, d, id, to);
         mPtr = (g + 1) % N_REQ;
         checkCount++; if (to || d !== expd[op]) $display("[TB] FAIL opcode_%0d_data: got %h expected %h", op, d, expd[op]); else passCount++;
         checkCount++; if (id !== 2'd2) $display("[TB] FAIL opcode_%0d_id: got %0d expected 2", op, id); else passCount++;
         req_valid = '0;
      end
      stepToIdle();
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] rv; int g, lat, expG; logic [WIDTH-1:0] d, expD; logic [IDW-1:0] id; bit to;
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      mPtr = 0;
      for (int k = 0; k < N_REQ; k++) setReq(k, 2'($urandom_range(0, 3)), $urandom, $urandom);
      req_valid = 4'hF;
      for (int i = 0; i < 6; i++) begin
         expG = modelWinner(req_valid);
         expD = expectFor(expG);
         runTxn(rv, g, lat, d, id, to);
         mPtr = (expG + 1) % N_REQ;
         checkCount++; if (to || g != expG) $display("[TB] FAIL rr_grant_%0d: got %0d expected %0d", i, g, expG); else passCount++;
         checkCount++; if (g != i % N_REQ) $display("[TB] FAIL rr_order_%0d: got %0d expected %0d", i, g, i % N_REQ); else passCount++;
         checkCount++; if (int'(id) != expG) $display("[TB] FAIL rr_id_%0d: got %0d expected %0d", i, id, expG); else passCount++;
         checkCount++; if (d !== expD) $display("[TB] FAIL rr_data_%0d: got %h expected %h", i, d, expD); else passCount++;
      end
      stepToIdle();
   endtask

   task automatic test_backpressure();
      logic [N_REQ-1:0] rv; int g, lat; logic [WIDTH-1:0] d, expD; logic [IDW-1:0] id; bit to;
      rsp_ready = 1'b0;
      setReq(1, 2'b10, $urandom, $urandom);
      expD = expectFor(1);
      req_valid = 4'b0010;
      runTxn(rv, g, lat, d, id, to);
      mPtr = (g + 1) % N_REQ;
      checkCount++; if (to || lat != 2) $display("[TB] FAIL bp_latency: got %0d expected 2", lat); else passCount++;
      checkCount++; if (d !== expD) $display("[TB] FAIL bp_data: got %h expected %h", d, expD); else passCount++;
      req_valid = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); @(negedge clk); #1;
         checkCount++;
         if (rsp_valid !== 1'b1 || rsp_data !== expD || rsp_id !== 2'd1 || req_ready !== 4'b0000)
            $display("[TB] FAIL bp_hold_%0d: got v=%b d=%h id=%0d rdy=%b expected v=1 d=%h id=1 rdy=0000",
                     c, rsp_valid, rsp_data, rsp_id, req_ready, expD);
         else passCount++;
      end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      checkCount++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL bp_release: got v=%b busy=%b expected 0 0", rsp_valid, busy); else passCount++;
      req_valid = '0;
      #1;
   endtask

   task automatic test_reset_midop();
      logic [N_REQ-1:0] rv; int g, lat; logic [WIDTH-1:0] d; logic [IDW-1:0] id; bit to;
      setReq(2, 2'b10, $urandom, $urandom);
      req_valid = 4'b0100;
      #1;
      checkCount++; if (req_ready !== 4'b0100) $display("[TB] FAIL midop_grant: got %b expected 0100", req_ready); else passCount++;
      @(posedge clk); @(negedge clk); #1;
      req_valid = '0;
      checkCount++; if (busy !== 1'b1 || req_ready !== 4'b0000) $display("[TB] FAIL midop_exec: got busy=%b rdy=%b expected 1 0000", busy, req_ready); else passCount++;
      rst = 1'b1;
      #1;
      checkCount++; if (busy !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) $display("[TB] FAIL midop_async_reset: got busy=%b d=%h id=%0d expected 0 0 0", busy, rsp_data, rsp_id); else passCount++;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); @(negedge clk); #1;
         if (c == 1) rst = 1'b0;
         checkCount++; if (rsp_valid !== 1'b0) $display("[TB] FAIL midop_no_rsp_%0d: got %b expected 0", c, rsp_valid); else passCount++;
      end
      mPtr = 0;
      req_valid = 4'b1010;
      #1;
      checkCount++; if (req_ready !== 4'b0010) $display("[TB] FAIL midop_next_grant: got %b expected 0010", req_ready); else passCount++;
      runTxn(rv, g, lat, d, id, to);
      mPtr = (g + 1) % N_REQ;
      checkCount++; if (to || id !== 2'd1) $display("[TB] FAIL midop_next_id: got %0d expected 1", id); else passCount++;
      stepToIdle();
   endtask

   task automatic test_forfeit();
      logic [N_REQ-1:0] rv; int g, lat, expG; logic [WIDTH-1:0] d; logic [IDW-1:0] id; bit to;
      setReq(2, 2'b01, $urandom, $urandom);
      req_valid = 4'b0100;
      runTxn(rv, g, lat, d, id, to);
      mPtr = (g + 1) % N_REQ;
      stepToIdle();
      req_valid = 4'b1010;
      #1;
      checkCount++; if (int'(req_ready) != (1 << modelWinner(4'b1010))) $display("[TB] FAIL forfeit_pre: got %b expected 1000", req_ready); else passCount++;
      req_valid = 4'b0010;
      #1;
      checkCount++; if (req_ready !== 4'b0010) $display("[TB] FAIL forfeit_switch: got %b expected 0010", req_ready); else passCount++;
      runTxn(rv, g, lat, d, id, to);
      checkCount++; if (to || g != 1) $display("[TB] FAIL forfeit_grant: got %0d expected 1", g); else passCount++;
      mPtr = (g + 1) % N_REQ;
      stepToIdle();
      req_valid = 4'b1010;
      expG = modelWinner(req_valid);
      #1;
      checkCount++; if (int'(req_ready) != (1 << expG) || expG != 3) $display("[TB] FAIL forfeit_next: got %b expected 1000", req_ready); else passCount++;
      req_valid = '0;
      #1;
   endtask

   task automatic test_random();
      logic [N_REQ-1:0] rv, mask; int g, lat, expG; logic [WIDTH-1:0] d, expD; logic [IDW-1:0] id; bit to;
      for (int i = 0; i < 20; i++) begin
         if (i % 5 == 4) begin
            req_valid = '0;
            repeat (2) begin
               @(posedge clk); @(negedge clk); #1;
            end
            checkCount++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) $display("[TB] FAIL rand_idle_%0d: got busy=%b v=%b rdy=%b expected 0 0 0000", i, busy, rsp_valid, req_ready); else passCount++;
         end
         mask = 4'($urandom_range(1, 15));
         for (int k = 0; k < N_REQ; k++) setReq(k, 2'($urandom_range(0, 3)), $urandom, $urandom);
         expG = modelWinner(mask);
         expD = expectFor(expG);
         req_valid = mask;
         runTxn(rv, g, lat, d, id, to);
         mPtr = (expG + 1) % N_REQ;
         checkCount++; if (to || rv !== 4'(1 << expG)) $display("[TB] FAIL rand_grant_%0d: got %b expected %b", i, rv, 4'(1 << expG)); else passCount++;
         checkCount++; if (lat != 2) $display("[TB] FAIL rand_latency_%0d: got %0d expected 2", i, lat); else passCount++;
         checkCount++; if (d !== expD || int'(id) != expG) $display("[TB] FAIL rand_rsp_%0d: got %h/%0d expected %h/%0d", i, d, id, expD, expG); else passCount++;
      end
      stepToIdle();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      test_reset();
      test_single();
      test_opcodes();
      test_round_robin();
      test_backpressure();
      test_reset_midop();
      test_forfeit();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
